// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider: FSM state type,
// its encoding constants and the default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_SIGN   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DIVIDE = ST_DIVIDE,
    SIGN   = ST_SIGN,
    DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/result handshake of the sequential divider.
// dz_o and its modport entries exist only when DIV_ZERO_DET_EN is defined.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic                    start;
  logic signed [WIDTH-1:0] dividend_i;
  logic signed [WIDTH-1:0] divisor_i;
  logic                    busy_o;
  logic                    done_o;
  logic signed [WIDTH-1:0] quotient_o;
  logic signed [WIDTH-1:0] remainder_o;
`ifdef DIV_ZERO_DET_EN
  logic                    dz_o;

  modport master (
    output start, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, dz_o
  );

  modport slave (
    input  start, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, dz_o
  );
`else
  modport master (
    output start, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o
  );

  modport slave (
    input  start, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o
  );
`endif

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes:
// shift {R,Q} left, trial-subtract the divisor, restore on a negative result.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dsor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One guard bit above the WIDTH+1 remainder keeps the trial sign unambiguous.
  logic        [WIDTH+1:0] shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    trial_neg;

  assign shifted   = {rem, quo[WIDTH-1]};
  assign trial     = signed'(shifted - {2'b00, dsor});
  assign trial_neg = trial[WIDTH+1];

  assign rem_next = trial_neg ? shifted[WIDTH:0] : unsigned'(trial[WIDTH:0]);
  assign quo_next = {quo[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, results
// truncated toward zero. Optional divide-by-zero detection via DIV_ZERO_DET_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [WIDTH:0]          rem;
  logic [WIDTH-1:0]        quo;
  logic [WIDTH-1:0]        dsor;
  logic                    dvd_neg;
  logic                    dsr_neg;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic signed [WIDTH-1:0] remainder;
  logic [WIDTH:0]          rem_next;
  logic [WIDTH-1:0]        quo_next;
`ifdef DIV_ZERO_DET_EN
  logic                    div_zero;
  logic                    dz;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] u;
    u = x;
    return x[WIDTH-1] ? (~u + WIDTH'(1)) : u;
  endfunction

  // Negation wraps, so the most negative value maps onto itself.
  function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                          input logic neg);
    return neg ? signed'(~m + WIDTH'(1)) : signed'(m);
  endfunction

  seq_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .dsor    (dsor),
    .rem_next(rem_next),
    .quo_next(quo_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      quo       <= '0;
      dsor      <= '0;
      dvd_neg   <= 1'b0;
      dsr_neg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DET_EN
      div_zero  <= 1'b0;
      dz        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Quotient register starts out holding |dividend|; it is shifted out into R.
            quo     <= magnitude(bus.dividend_i);
            dsor    <= magnitude(bus.divisor_i);
            dvd_neg <= bus.dividend_i[WIDTH-1];
            dsr_neg <= bus.divisor_i[WIDTH-1];
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
`ifdef DIV_ZERO_DET_EN
            dz       <= 1'b0;
            div_zero <= (bus.divisor_i == '0);
            state    <= (bus.divisor_i == '0) ? SIGN : DIVIDE;
`else
            state    <= DIVIDE;
`endif
          end
        end
        DIVIDE: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          busy <= 1'b0;
`ifdef DIV_ZERO_DET_EN
          if (div_zero) begin
            quotient  <= '1;
            remainder <= apply_sign(quo, dvd_neg);
          end else begin
            quotient  <= apply_sign(quo, dvd_neg ^ dsr_neg);
            remainder <= apply_sign(rem[WIDTH-1:0], dvd_neg);
          end
`else
          quotient  <= apply_sign(quo, dvd_neg ^ dsr_neg);
          remainder <= apply_sign(rem[WIDTH-1:0], dvd_neg);
`endif
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
`ifdef DIV_ZERO_DET_EN
          dz    <= div_zero;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.quotient_o  = quotient;
  assign bus.remainder_o = remainder;
`ifdef DIV_ZERO_DET_EN
  assign bus.dz_o        = dz;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a scoreboard queue of arithmetic
// expectations, drained by a monitor on every done_o pulse.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct {
    int q;
    int r;
    int lat;
    bit dz;
    int start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int x);
    logic signed [W-1:0] t;
    t = x[W-1:0];
    return int'(t);
  endfunction

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.lat = W + 2;
    e.dz  = 1'b0;
    e.start_cyc = 0;
    if (b == 0) begin
      e.r = a;
`ifdef DIV_ZERO_DET_EN
      e.q   = -1;
      e.lat = 2;
      e.dz  = 1'b1;
`else
      e.q   = (a < 0) ? 1 : -1;
`endif
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.q = wrap(e.q);
    e.r = wrap(e.r);
    return e;
  endfunction

  task automatic start_op(input int a, input int b, input bit push, output int exp_busy);
    exp_t e;
    e = model(a, b);
    exp_busy = (e.lat == 2) ? 1 : W + 1;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dividend_i = a[W-1:0];
    bus.divisor_i  = b[W-1:0];
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    if (push) sb.push_back(e);
    bus.start      = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
  endtask

  task automatic wait_done(input int exp_busy);
    int nb;
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.busy_o) nb++;
      if (bus.done_o) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    if (exp_busy >= 0) chk("busy_cycles", nb, exp_busy);
  endtask

  task automatic run_op(input int a, input int b);
    int eb;
    start_op(a, b, 1'b1, eb);
    wait_done(eb);
  endtask

  always @(negedge clk) begin
    if (bus.done_o) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", int'(bus.quotient_o), e.q);
        chk("remainder", int'(bus.remainder_o), e.r);
        chk("latency", cyc - e.start_cyc, e.lat);
`ifdef DIV_ZERO_DET_EN
        chk("dz", int'(bus.dz_o), int'(e.dz));
`endif
      end
    end
  end

  initial begin
    int eb;
    bus.start      = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_q", int'(bus.quotient_o), 0);
    chk("rst_r", int'(bus.remainder_o), 0);
`ifdef DIV_ZERO_DET_EN
    chk("rst_dz", int'(bus.dz_o), 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    run_op(7, 2);
    run_op(-7, 2);
    run_op(7, -2);
    run_op(-7, -2);
    run_op(-8, -1);
    run_op(-8, 1);
    run_op(5, 0);
    run_op(-8, 0);
    run_op(6, 3);

    // A second start while busy must be dropped, not queued.
    start_op(7, 2, 1'b1, eb);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.dividend_i = 4'sd6;
    bus.divisor_i  = 4'sd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(-1);
    repeat (W + 4) @(negedge clk);

    // Results hold during a later computation; reset mid-DIVIDE clears everything.
    start_op(7, -1, 1'b0, eb);
    repeat (2) @(negedge clk);
    chk("hold_q", int'(bus.quotient_o), 3);
    chk("hold_r", int'(bus.remainder_o), 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy_o), 0);
    chk("midrst_done", int'(bus.done_o), 0);
    chk("midrst_q", int'(bus.quotient_o), 0);
    chk("midrst_r", int'(bus.remainder_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (W + 4) @(negedge clk);
    run_op(6, 3);

    for (int i = 0; i < 24; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 15)) - 8;
      b = int'($urandom_range(0, 15)) - 8;
      run_op(a, b);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
